// File: rtl/rvfi_retire_fifo.sv
// Retirement record FIFO between the RVFI port and downstream register-consistency checkers.
// Each record carries a sequence tag. Records that arrive while the FIFO is full are dropped,
// and every drop is counted.
module rvfi_retire_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQ_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid,
    input  logic [4:0]               in_rd_addr,
    input  logic [31:0]              in_rd_wdata,
    input  logic [4:0]               in_rs1_addr,
    input  logic [31:0]              in_rs1_rdata,
    input  logic [4:0]               in_rs2_addr,
    input  logic [31:0]              in_rs2_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_rd_addr,
    output logic [31:0]              out_rd_wdata,
    output logic [4:0]               out_rs1_addr,
    output logic [31:0]              out_rs1_rdata,
    output logic [4:0]               out_rs2_addr,
    output logic [31:0]              out_rs2_rdata,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned REC_W = 111;
    localparam int unsigned ENT_W = REC_W + SEQ_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [SEQ_W-1:0] seq;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic             drop;

    // Pointer-based status and handshake qualification
    assign empty     = (wptr == rptr);
    assign full      = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign accept    = in_valid && (!full || pop);
    assign drop      = in_valid && !accept;

    // Head record is read straight from storage; no bypass from the inputs
    assign head = mem[rptr[AW-1:0]];
    assign {out_seq, out_rd_addr, out_rd_wdata, out_rs1_addr,
            out_rs1_rdata, out_rs2_addr, out_rs2_rdata} = head;

    // Record storage, written verbatim with the pre-increment sequence tag
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept) begin
            mem[wptr[AW-1:0]] <= {seq, in_rd_addr, in_rd_wdata, in_rs1_addr,
                                  in_rs1_rdata, in_rs2_addr, in_rs2_rdata};
        end
    end

    // Pointers, occupancy, sequence counter and drop accounting
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + PTR_W'(accept) - PTR_W'(pop);
            if (in_valid) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Structural invariants
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= PTR_W'(DEPTH));
    a_valid_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid == (count != '0));
    a_no_overrun: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(full && accept && !pop));
    a_overflow_sticky: assert property (@(posedge clk_i)
        ($past(rst_ni) && $past(overflow)) |-> overflow);

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Directed bench for rvfi_retire_fifo: vector table plus hand-written wrap/saturation sequences.
module tb_rvfi_retire_fifo;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [31:0] rd_d, rs1_d, rs2_d;

    logic        ov_valid, nv_valid;
    logic [4:0]  o_rd_a, o_rs1_a, o_rs2_a, n_rd_a, n_rs1_a, n_rs2_a;
    logic [31:0] o_rd_d, o_rs1_d, o_rs2_d, n_rd_d, n_rs1_d, n_rs2_d;
    logic [31:0] o_seq;
    logic [3:0]  n_seq;
    logic [2:0]  o_cnt, n_cnt;
    logic        o_ovf, n_ovf;
    logic [7:0]  o_dc, n_dc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvfi_retire_fifo #(.DEPTH(4), .SEQ_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid(in_valid),
        .in_rd_addr(rd_a), .in_rd_wdata(rd_d), .in_rs1_addr(rs1_a),
        .in_rs1_rdata(rs1_d), .in_rs2_addr(rs2_a), .in_rs2_rdata(rs2_d),
        .out_valid(ov_valid), .out_ready(out_ready),
        .out_rd_addr(o_rd_a), .out_rd_wdata(o_rd_d), .out_rs1_addr(o_rs1_a),
        .out_rs1_rdata(o_rs1_d), .out_rs2_addr(o_rs2_a), .out_rs2_rdata(o_rs2_d),
        .out_seq(o_seq), .count(o_cnt), .overflow(o_ovf), .drop_cnt(o_dc)
    );

    rvfi_retire_fifo #(.DEPTH(4), .SEQ_W(4)) dut_n (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid(in_valid),
        .in_rd_addr(rd_a), .in_rd_wdata(rd_d), .in_rs1_addr(rs1_a),
        .in_rs1_rdata(rs1_d), .in_rs2_addr(rs2_a), .in_rs2_rdata(rs2_d),
        .out_valid(nv_valid), .out_ready(out_ready),
        .out_rd_addr(n_rd_a), .out_rd_wdata(n_rd_d), .out_rs1_addr(n_rs1_a),
        .out_rs1_rdata(n_rs1_d), .out_rs2_addr(n_rs2_a), .out_rs2_rdata(n_rs2_d),
        .out_seq(n_seq), .count(n_cnt), .overflow(n_ovf), .drop_cnt(n_dc)
    );

    typedef struct {
        bit          rst_n;
        bit          vld;
        int unsigned tag;
        bit          rdy;
        int unsigned e_cnt;
        bit          e_vld;
        int unsigned e_head;
        bit          e_ovf;
        int unsigned e_dc;
    } vec_t;

    vec_t vecs[$];

    // Deterministic record contents for a given tag
    function automatic logic [110:0] rec(int unsigned t);
        return {5'(t * 3 + 1), 32'hD000_0000 | t, 5'(t + 2),
                32'h1111_0000 + t, 5'(31 - t), ~t};
    endfunction

    function automatic void add(bit r, bit v, int unsigned t, bit rdy,
                                int unsigned c, bit ev, int unsigned h,
                                bit ef, int unsigned d);
        vec_t x;
        x.rst_n = r; x.vld = v; x.tag = t; x.rdy = rdy;
        x.e_cnt = c; x.e_vld = ev; x.e_head = h; x.e_ovf = ef; x.e_dc = d;
        vecs.push_back(x);
    endfunction

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit v, int unsigned t, bit rdy);
        @(negedge clk);
        rst_ni    = r;
        in_valid  = v;
        out_ready = rdy;
        {rd_a, rd_d, rs1_a, rs1_d, rs2_a, rs2_d} = rec(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {rd_a, rd_d, rs1_a, rs1_d, rs2_a, rs2_d} = '0;

        // Reset with in_valid high, which must be ignored
        add(0, 1, 99, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill to DEPTH with the consumer stalled
        for (int t = 0; t < 4; t++) add(1, 1, t, 0, t + 1, 1, 0, 0, 0);
        // Drop while full, then seq 5 follows 3 after the gap
        add(1, 1, 4, 0, 4, 1, 0, 1, 1);
        add(1, 0, 0, 1, 3, 1, 1, 1, 1);
        add(1, 1, 5, 0, 4, 1, 1, 1, 1);
        add(1, 0, 0, 1, 3, 1, 2, 1, 1);
        add(1, 0, 0, 1, 2, 1, 3, 1, 1);
        add(1, 0, 0, 1, 1, 1, 5, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1, 1);
        // Push and pop on the same cycle while full
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 4; t++) add(1, 1, t, 0, t + 1, 1, 0, 0, 0);
        add(1, 1, 4, 1, 4, 1, 1, 0, 0);
        add(1, 0, 0, 1, 3, 1, 2, 0, 0);
        add(1, 0, 0, 1, 2, 1, 3, 0, 0);
        add(1, 0, 0, 1, 1, 1, 4, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Streaming push+pop of 10 records, pointers wrapping
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 0, 0);
        for (int k = 1; k < 10; k++) add(1, 1, k, 1, 1, 1, k, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Mid-stream reset with in_valid high
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 2, 1, 0, 0, 0);
        add(0, 1, 7, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].vld, vecs[i].tag, vecs[i].rdy);
            check($sformatf("v%0d count", i), 128'(o_cnt), 128'(vecs[i].e_cnt));
            check($sformatf("v%0d out_valid", i), 128'(ov_valid), 128'(vecs[i].e_vld));
            check($sformatf("v%0d overflow", i), 128'(o_ovf), 128'(vecs[i].e_ovf));
            check($sformatf("v%0d drop_cnt", i), 128'(o_dc), 128'(vecs[i].e_dc));
            if (vecs[i].e_vld) begin
                check($sformatf("v%0d out_seq", i), 128'(o_seq), 128'(vecs[i].e_head));
                check($sformatf("v%0d fields", i),
                      128'({o_rd_a, o_rd_d, o_rs1_a, o_rs1_d, o_rs2_a, o_rs2_d}),
                      128'(rec(vecs[i].e_head)));
            end
        end

        // Sequence wrap on the 4-bit instance over 17 retirements
        drive(0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, k, 1);
            check($sformatf("wrap%0d seq32", k), 128'(o_seq), 128'(k));
            check($sformatf("wrap%0d seq4", k), 128'(n_seq), 128'(k % 16));
            check($sformatf("wrap%0d count", k), 128'(n_cnt), 128'd1);
        end
        drive(1, 0, 0, 1);
        check("wrap drained", 128'(nv_valid), 128'd0);

        // Fill, then 257 drops to saturate drop_cnt
        for (int k = 17; k < 21; k++) drive(1, 1, k, 0);
        for (int i = 1; i <= 257; i++) begin
            drive(1, 1, 1000 + i, 0);
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 257) begin
                check($sformatf("sat%0d drop_cnt", i), 128'(o_dc),
                      128'((i > 255) ? 255 : i));
                check($sformatf("sat%0d drop_cnt4", i), 128'(n_dc),
                      128'((i > 255) ? 255 : i));
            end
        end
        check("sat overflow", 128'(o_ovf), 128'd1);
        check("sat count", 128'(o_cnt), 128'd4);
        check("sat head seq", 128'(o_seq), 128'd17);
        check("sat head fields",
              128'({o_rd_a, o_rd_d, o_rs1_a, o_rs1_d, o_rs2_a, o_rs2_d}),
              128'(rec(17)));
        drive(1, 0, 0, 1);
        check("sat next seq", 128'(o_seq), 128'd18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
